// File: rtl/ldst_pkg.sv
// Shared types for the ldst_req/ldst_rsp channel between the execution unit and the
// memory-side responder.
package ldst_pkg;

    localparam int BYTE_LANES = 4;

    typedef enum logic [1:0] {
        LDST_B = 2'd0,
        LDST_H = 2'd1,
        LDST_W = 2'd2
    } ldst_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RSP   = 2'd3
    } ldst_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        st;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } ldst_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } ldst_rsp_t;

    // Size code 3 has no access width, so it is always treated as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            2'd1:    bad = addr_lo[0];
            2'd2:    bad = (addr_lo != 2'b00);
            2'd3:    bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ldst_lane_align.sv
// Byte-lane steering for a 32-bit SRAM: store enables/replication, load shift and
// extension, plus the alignment check.
module ldst_lane_align
    import ldst_pkg::*;
(
    input  logic [1:0]                i_addr_lo,
    input  logic [1:0]                i_size,
    input  logic                      i_uns,
    input  logic [BYTE_LANES*8-1:0]   i_wdata,
    input  logic [BYTE_LANES*8-1:0]   i_rdata,
    output logic [BYTE_LANES-1:0]     o_be,
    output logic [BYTE_LANES*8-1:0]   o_repl_wdata,
    output logic [BYTE_LANES*8-1:0]   o_ext_rdata,
    output logic                      o_misaligned
);

    logic [BYTE_LANES*8-1:0] w_shift;
    logic                    w_sext;

    assign w_shift      = i_rdata >> {i_addr_lo, 3'b000};
    assign o_misaligned = is_misaligned(i_size, i_addr_lo);

    always_comb begin
        o_be         = '0;
        o_repl_wdata = i_wdata;
        o_ext_rdata  = '0;
        w_sext       = 1'b0;
        case (i_size)
            LDST_B: begin
                o_be         = 4'b0001 << i_addr_lo;
                o_repl_wdata = {4{i_wdata[7:0]}};
                w_sext       = ~i_uns & w_shift[7];
                o_ext_rdata  = {{24{w_sext}}, w_shift[7:0]};
            end
            LDST_H: begin
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_repl_wdata = {2{i_wdata[15:0]}};
                w_sext       = ~i_uns & w_shift[15];
                o_ext_rdata  = {{16{w_sext}}, w_shift[15:0]};
            end
            LDST_W: begin
                o_be         = 4'hF;
                o_ext_rdata  = w_shift;
            end
            default: begin
                o_be         = '0;
                o_ext_rdata  = '0;
            end
        endcase
    end

endmodule

// File: rtl/ldst_responder.sv
// Memory-side responder: one outstanding load/store, fixed-latency SRAM access,
// response held until the requester takes it.
module ldst_responder
    import ldst_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ldst_req_vld,
    output logic          ldst_req_rdy,
    input  logic [AW-1:0] ldst_req_addr,
    input  logic          ldst_req_st,
    input  logic [1:0]    ldst_req_size,
    input  logic          ldst_req_uns,
    input  logic [DW-1:0] ldst_req_wdata,
    output logic          ldst_rsp_vld,
    input  logic          ldst_rsp_rdy,
    output logic [DW-1:0] ldst_rsp_rdata,
    output logic          ldst_rsp_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MEM_LAT + 1);

    ldst_state_e r_state, w_next;
    logic [AW-1:0] r_addr;
    logic          r_st;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [DW-1:0] r_wdata;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_rdata;
    logic          r_err;

    logic [1:0]    w_addr_lo;
    logic [1:0]    w_size;
    logic [3:0]    w_be;
    logic [DW-1:0] w_repl_wdata;
    logic [DW-1:0] w_ext_rdata;
    logic          w_misaligned;
    logic          w_accept;
    logic          w_last;

    // In IDLE the alignment check must see the live request, afterwards the latched one.
    assign w_addr_lo = (r_state == IDLE) ? ldst_req_addr[1:0] : r_addr[1:0];
    assign w_size    = (r_state == IDLE) ? ldst_req_size      : r_size;
    assign w_accept  = (r_state == IDLE) && ldst_req_vld;
    assign w_last    = (r_state == WAIT) && (r_cnt == CW'(MEM_LAT - 1));

    ldst_lane_align u_align (
        .i_addr_lo    (w_addr_lo),
        .i_size       (w_size),
        .i_uns        (r_uns),
        .i_wdata      (r_wdata),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_repl_wdata (w_repl_wdata),
        .o_ext_rdata  (w_ext_rdata),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        ldst_req_rdy   = 1'b0;
        ldst_rsp_vld   = 1'b0;
        ldst_rsp_rdata = '0;
        ldst_rsp_err   = 1'b0;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_be         = '0;
        mem_addr       = '0;
        mem_wdata      = '0;
        case (r_state)
            IDLE: begin
                ldst_req_rdy = 1'b1;
                if (ldst_req_vld) begin
                    w_next = w_misaligned ? RSP : ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = r_st;
                mem_be    = w_be;
                mem_addr  = {r_addr[AW-1:2], 2'b00};
                mem_wdata = w_repl_wdata;
                w_next    = WAIT;
            end
            WAIT: begin
                if (w_last) begin
                    w_next = RSP;
                end
            end
            RSP: begin
                ldst_rsp_vld   = 1'b1;
                ldst_rsp_rdata = r_rdata;
                ldst_rsp_err   = r_err;
                if (ldst_rsp_rdy) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_st    <= 1'b0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= ldst_req_addr;
                r_st    <= ldst_req_st;
                r_size  <= ldst_req_size;
                r_uns   <= ldst_req_uns;
                r_wdata <= ldst_req_wdata;
                r_err   <= w_misaligned;
                r_rdata <= '0;
            end
            if (r_state == ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Stores report zero data; loads take the SRAM word on its valid cycle.
            if (w_last) begin
                r_rdata <= r_st ? '0 : w_ext_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ldst_responder.sv
// Directed bench for ldst_responder with a fixed-latency SRAM model that only
// presents valid read data on the exact cycle it is due.
module tb_ldst_responder;

    localparam int MEM_LAT = 2;

    logic        clk;
    logic        rst;
    logic        ldst_req_vld;
    logic        ldst_req_rdy;
    logic [31:0] ldst_req_addr;
    logic        ldst_req_st;
    logic [1:0]  ldst_req_size;
    logic        ldst_req_uns;
    logic [31:0] ldst_req_wdata;
    logic        ldst_rsp_vld;
    logic        ldst_rsp_rdy;
    logic [31:0] ldst_rsp_rdata;
    logic        ldst_rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    // Results captured by txn
    int          t_lat;
    int          t_pulses;
    int          t_rdy_hi;
    logic [31:0] t_be;
    logic [31:0] t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;

    logic [MEM_LAT-1:0] en_pipe;
    logic [31:0]        sram_word;

    ldst_responder #(.MEM_LAT(MEM_LAT), .AW(32), .DW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ldst_req_vld   (ldst_req_vld),
        .ldst_req_rdy   (ldst_req_rdy),
        .ldst_req_addr  (ldst_req_addr),
        .ldst_req_st    (ldst_req_st),
        .ldst_req_size  (ldst_req_size),
        .ldst_req_uns   (ldst_req_uns),
        .ldst_req_wdata (ldst_req_wdata),
        .ldst_rsp_vld   (ldst_rsp_vld),
        .ldst_rsp_rdy   (ldst_rsp_rdy),
        .ldst_rsp_rdata (ldst_rsp_rdata),
        .ldst_rsp_err   (ldst_rsp_err),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_be         (mem_be),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data is only meaningful MEM_LAT cycles after mem_en; garbage otherwise.
    always @(posedge clk or posedge rst) begin
        if (rst) en_pipe <= '0;
        else     en_pipe <= {en_pipe[MEM_LAT-2:0], mem_en};
    end
    assign mem_rdata = en_pipe[MEM_LAT-1] ? sram_word : 32'h5A5A_A5A5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Drive one request at the current negedge and run until rsp_vld (bounded).
    task automatic txn(input logic [31:0] addr, input logic st, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic hold_vld);
        ldst_req_addr  = addr;
        ldst_req_st    = st;
        ldst_req_size  = size;
        ldst_req_uns   = uns;
        ldst_req_wdata = wdata;
        ldst_req_vld   = 1'b1;
        t_lat = 0; t_pulses = 0; t_rdy_hi = 0;
        t_be = '0; t_we = '0; t_addr = '0; t_wdata = '0;
        do begin
            @(negedge clk);
            t_lat++;
            if (!hold_vld) ldst_req_vld = 1'b0;
            if (mem_en) begin
                t_pulses++;
                t_be    = 32'(mem_be);
                t_we    = 32'(mem_we);
                t_addr  = mem_addr;
                t_wdata = mem_wdata;
            end
            if (ldst_req_rdy) t_rdy_hi++;
        end while (!ldst_rsp_vld && t_lat < 30);
    endtask

    task automatic finish_rsp(input string tag);
        ldst_rsp_rdy = 1'b1;
        @(negedge clk);
        ldst_rsp_rdy = 1'b0;
        check({tag, "_idle_vld"}, 32'(ldst_rsp_vld), 32'd0);
        check({tag, "_idle_rdy"}, 32'(ldst_req_rdy), 32'd1);
    endtask

    initial begin
        int vld_seen;
        rst = 1'b1;
        ldst_req_vld = 1'b0; ldst_req_addr = '0; ldst_req_st = 1'b0;
        ldst_req_size = '0; ldst_req_uns = 1'b0; ldst_req_wdata = '0;
        ldst_rsp_rdy = 1'b0; sram_word = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_rdy",   32'(ldst_req_rdy),   32'd1);
        check("rst_vld",   32'(ldst_rsp_vld),   32'd0);
        check("rst_err",   32'(ldst_rsp_err),   32'd0);
        check("rst_rdata", ldst_rsp_rdata,      32'd0);
        check("rst_en",    32'(mem_en),         32'd0);
        check("rst_we",    32'(mem_we),         32'd0);
        check("rst_be",    32'(mem_be),         32'd0);

        // lw 0x100
        sram_word = 32'hDEAD_BEEF;
        txn(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
        check("lw_lat",    32'(t_lat),    32'd4);
        check("lw_pulses", 32'(t_pulses), 32'd1);
        check("lw_be",     t_be,          32'hF);
        check("lw_we",     t_we,          32'd0);
        check("lw_addr",   t_addr,        32'h100);
        check("lw_rdy",    32'(t_rdy_hi), 32'd0);
        check("lw_rdata",  ldst_rsp_rdata, 32'hDEAD_BEEF);
        check("lw_err",    32'(ldst_rsp_err), 32'd0);
        finish_rsp("lw");

        // lb / lbu 0x103
        sram_word = 32'h80FF_1234;
        txn(32'h103, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        check("lb_rdata", ldst_rsp_rdata, 32'hFFFF_FF80);
        check("lb_addr",  t_addr,         32'h100);
        check("lb_be",    t_be,           32'h8);
        finish_rsp("lb");
        txn(32'h103, 1'b0, 2'd0, 1'b1, 32'h0, 1'b0);
        check("lbu_rdata", ldst_rsp_rdata, 32'h0000_0080);
        check("lbu_addr",  t_addr,         32'h100);
        finish_rsp("lbu");

        // lh / lhu 0x102, lh 0x100
        txn(32'h102, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0);
        check("lh_hi_rdata", ldst_rsp_rdata, 32'hFFFF_80FF);
        finish_rsp("lh_hi");
        txn(32'h102, 1'b0, 2'd1, 1'b1, 32'h0, 1'b0);
        check("lhu_hi_rdata", ldst_rsp_rdata, 32'h0000_80FF);
        finish_rsp("lhu_hi");
        txn(32'h100, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0);
        check("lh_lo_rdata", ldst_rsp_rdata, 32'h0000_1234);
        check("lh_lo_be",    t_be,           32'h3);
        finish_rsp("lh_lo");

        // word load ignores uns
        txn(32'h100, 1'b0, 2'd2, 1'b1, 32'h0, 1'b0);
        check("lwu_rdata", ldst_rsp_rdata, 32'h80FF_1234);
        finish_rsp("lwu");

        // sh 0x102
        sram_word = 32'hFFFF_FFFF;
        txn(32'h102, 1'b1, 2'd1, 1'b0, 32'h0000_ABCD, 1'b0);
        check("sh_lat",   32'(t_lat), 32'd4);
        check("sh_we",    t_we,       32'd1);
        check("sh_be",    t_be,       32'hC);
        check("sh_wdata", t_wdata,    32'hABCD_ABCD);
        check("sh_addr",  t_addr,     32'h100);
        check("sh_rdata", ldst_rsp_rdata, 32'd0);
        check("sh_err",   32'(ldst_rsp_err), 32'd0);
        finish_rsp("sh");

        // sb 0x101, sw 0x104
        txn(32'h101, 1'b1, 2'd0, 1'b0, 32'h1234_5677, 1'b0);
        check("sb_be",    t_be,    32'h2);
        check("sb_wdata", t_wdata, 32'h7777_7777);
        finish_rsp("sb");
        txn(32'h104, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0);
        check("sw_be",    t_be,    32'hF);
        check("sw_wdata", t_wdata, 32'hCAFE_F00D);
        check("sw_addr",  t_addr,  32'h104);
        finish_rsp("sw");

        // error cases: misaligned word, misaligned half, illegal size
        sram_word = 32'h1111_1111;
        txn(32'h101, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
        check("mis_w_lat",    32'(t_lat),    32'd1);
        check("mis_w_pulses", 32'(t_pulses), 32'd0);
        check("mis_w_err",    32'(ldst_rsp_err), 32'd1);
        check("mis_w_rdata",  ldst_rsp_rdata, 32'd0);
        finish_rsp("mis_w");
        txn(32'h103, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0);
        check("mis_h_err",    32'(ldst_rsp_err), 32'd1);
        check("mis_h_pulses", 32'(t_pulses), 32'd0);
        finish_rsp("mis_h");
        txn(32'h100, 1'b1, 2'd3, 1'b0, 32'hFFFF_FFFF, 1'b0);
        check("ill_lat",    32'(t_lat),    32'd1);
        check("ill_pulses", 32'(t_pulses), 32'd0);
        check("ill_err",    32'(ldst_rsp_err), 32'd1);
        check("ill_rdata",  ldst_rsp_rdata, 32'd0);
        finish_rsp("ill");

        // backpressure with vld held high through the response
        sram_word = 32'h1122_3344;
        txn(32'h200, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1);
        check("bp_lat",    32'(t_lat),    32'd4);
        check("bp_rdy",    32'(t_rdy_hi), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_vld",   32'(ldst_rsp_vld), 32'd1);
            check("bp_rdata", ldst_rsp_rdata,    32'h1122_3344);
            check("bp_err",   32'(ldst_rsp_err), 32'd0);
            check("bp_reqrdy", 32'(ldst_req_rdy), 32'd0);
            check("bp_en",    32'(mem_en),       32'd0);
        end
        ldst_rsp_rdy = 1'b1;
        @(negedge clk);
        ldst_rsp_rdy = 1'b0;
        ldst_req_vld = 1'b0;
        check("bp_idle_vld", 32'(ldst_rsp_vld), 32'd0);
        check("bp_idle_rdy", 32'(ldst_req_rdy), 32'd1);
        @(negedge clk);
        check("bp_no_reaccept", 32'(mem_en), 32'd0);

        // reset during WAIT
        sram_word = 32'h0BAD_F00D;
        ldst_req_addr = 32'h300; ldst_req_st = 1'b0; ldst_req_size = 2'd2; ldst_req_uns = 1'b0;
        ldst_req_vld = 1'b1;
        @(negedge clk);
        ldst_req_vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rw_vld",   32'(ldst_rsp_vld), 32'd0);
        check("rw_rdy",   32'(ldst_req_rdy), 32'd1);
        check("rw_en",    32'(mem_en),       32'd0);
        check("rw_rdata", ldst_rsp_rdata,    32'd0);
        @(negedge clk);
        rst = 1'b0;
        vld_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ldst_rsp_vld) vld_seen++;
        end
        check("rw_no_stale", 32'(vld_seen), 32'd0);

        // reset during ISSUE drops mem_en asynchronously
        ldst_req_vld = 1'b1;
        @(negedge clk);
        ldst_req_vld = 1'b0;
        check("ri_en_before", 32'(mem_en), 32'd1);
        rst = 1'b1;
        #1;
        check("ri_en_after", 32'(mem_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        txn(32'h300, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
        check("post_rst_lat",   32'(t_lat),    32'd4);
        check("post_rst_rdata", ldst_rsp_rdata, 32'h0BAD_F00D);
        check("post_rst_err",   32'(ldst_rsp_err), 32'd0);
        finish_rsp("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ldst_responder.md
Name: ldst_responder

Overview:
Memory-side end of the ldst_req/ldst_rsp protocol that the execution unit masters. It accepts one load/store request at a time and performs a byte, halfword or word access on a single-port data SRAM with fixed read latency. It returns a response carrying aligned, extended load data or an error flag. It sits between the core's ldst channel and the data memory and has at most one outstanding transaction.

Parameters:
MEM_LAT, 1, SRAM read latency in cycles from mem_en to valid mem_rdata (legal range ≥1)
AW, 32, address width
DW, 32, data width (fixed at 32; byte lanes = 4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ldst_req_vld  in  1  request valid
ldst_req_rdy  out  1  request ready
ldst_req_addr  in  AW  byte address
ldst_req_st  in  1  1=store, 0=load
ldst_req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
ldst_req_uns  in  1  load zero-extend (lbu/lhu)
ldst_req_wdata  in  DW  store data, right-aligned
ldst_rsp_vld  out  1  response valid
ldst_rsp_rdy  in  1  response ready
ldst_rsp_rdata  out  DW  load result (0 for stores/errors)
ldst_rsp_err  out  1  misaligned or illegal size
mem_en  out  1  SRAM access strobe
mem_we  out  1  SRAM write enable
mem_be  out  4  byte enables
mem_addr  out  AW  word address {addr[AW-1:2],2'b00}
mem_wdata  out  DW  lane-replicated store data
mem_rdata  in  DW  SRAM read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port rst.
- FSM states: IDLE, ISSUE, WAIT, RSP. Reset state is IDLE.
- Reset values: rdy=1 (from IDLE); rsp_vld=0; rsp_err=0; rsp_rdata=0; mem_en=0; mem_we=0; mem_be=0; cnt=0.
- IDLE: req_rdy=1; all other outputs low.
  - On vld&rdy, latch addr, st, size, uns and wdata.
  - If misaligned or illegal size, go to RSP with err=1 and rdata=0. No SRAM access occurs.
  - Otherwise go to ISSUE.
- Misaligned is defined as: size==1 with addr[0]==1; size==2 with addr[1:0]!=0; or size==3.
- ISSUE (exactly one cycle): mem_en=1; mem_we=st; mem_be and mem_wdata come from the lane logic. Clear cnt, then go to WAIT.
- WAIT: cnt increments each cycle. When cnt==MEM_LAT-1:
  - for loads, capture the extended mem_rdata into rsp_rdata;
  - for stores, set rsp_rdata=0;
  - go to RSP.
  - WAIT therefore lasts exactly MEM_LAT cycles.
- RSP: rsp_vld=1, with rdata and err held stable. On rsp_rdy, go to IDLE. rsp_vld falls in the next cycle.
  - There is no back-to-back acceptance in the handshake cycle, because req_rdy=0 outside IDLE.
- Latency, with acceptance at cycle T:
  - normal access: rsp_vld first high at T+2+MEM_LAT;
  - error: rsp_vld first high at T+1.
- Store lanes:
  - byte: be = 1<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - word: be = 4'hF.
- Load extraction: shift mem_rdata right by 8*addr[1:0], truncate to size, then sign-extend unless uns. Word loads ignore uns. For loads, mem_be is the same as for stores (informational).
- Request inputs are only sampled at acceptance. The requester may hold vld high through the response; the held request is not re-accepted until IDLE.
- rst asserted mid-transaction: return to IDLE immediately and drop any pending response. mem_en deasserts asynchronously with reset.

Decomposition:
- Shared package ldst_pkg holds:
  - enum ldst_size_e {LDST_B, LDST_H, LDST_W};
  - the state enum;
  - localparam BYTE_LANES=4;
  - the request/response packet structs, shared with the execution-side master.
- One combinational sub-module, ldst_lane_align: takes addr[1:0], size, uns, wdata and rdata, and produces be, repl_wdata, ext_rdata and misaligned.
- The responder keeps the FSM, the counter and the response registers.

Test Plan:
- lw from 0x100 with MEM_LAT=2, SRAM returning 0xDEADBEEF -> mem_en one cycle at T+1 with be=4'hF and we=0; rsp_vld at T+4 with rdata=0xDEADBEEF and err=0.
- lb from 0x103 with mem_rdata=0x80FF1234 -> rdata=0xFFFFFF80; same access as lbu -> rdata=0x00000080; mem_addr=0x100 in both cases.
- sh to 0x102 with wdata=0x0000ABCD -> mem_we=1, be=4'b1100, mem_wdata=0xABCDABCD; response rdata=0, err=0.
- lw from 0x101, and a size=3 request -> mem_en never asserted; rsp_vld at T+1 with err=1 and rdata=0.
- Backpressure: hold rsp_rdy=0 for 5 cycles in RSP -> rsp_vld, rdata and err stable; req_rdy=0 while vld is held high; exactly one mem_en pulse; IDLE one cycle after rsp_rdy.
- Assert rst during WAIT -> outputs return to reset values immediately, with no stale rsp_vld after release; a new lw completes normally.
